// File: rtl/sram_arbiter.sv
// Two-port fixed-priority arbiter in front of the data SRAM.
// Port 0 (MEM stage) normally wins; port 1 is forced through after MAX_WAIT lost cycles.
module sram_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    input  logic [DATA_W/8-1:0]   p0_wmask,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_W-1:0]     p0_rdata,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    input  logic [DATA_W/8-1:0]   p1_wmask,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_W-1:0]     p1_rdata,

    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    output logic [DATA_W/8-1:0]   sram_wmask,
    input  logic [DATA_W-1:0]     sram_rdata,

    output logic [15:0]           conflict_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic [1:0]        rd_pend;

    // Zero-cycle arbitration; the idle cycle leaves the port 0 fields on the bus.
    always_comb begin
        p0_gnt     = 1'b0;
        p1_gnt     = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = p0_addr;
        sram_wdata = p0_wdata;
        sram_wmask = p0_wmask;

        if (p1_req && (!p0_req || wait_cnt == WAIT_MAX)) begin
            p1_gnt     = 1'b1;
            sram_we    = p1_we;
            sram_addr  = p1_addr;
            sram_wdata = p1_wdata;
            sram_wmask = p1_wmask;
        end else if (p0_req) begin
            p0_gnt  = 1'b1;
            sram_we = p0_we;
        end

        sram_cs = p0_gnt | p1_gnt;
    end

    always_comb begin
        wait_cnt_next = wait_cnt;
        if (!p1_req || p1_gnt) begin
            wait_cnt_next = '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend      <= 2'b00;
            wait_cnt     <= '0;
            conflict_cnt <= 16'd0;
        end else begin
            rd_pend  <= {p1_gnt & ~p1_we, p0_gnt & ~p0_we};
            wait_cnt <= wait_cnt_next;
            if (p0_req && p1_req && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    // Both ports see the raw SRAM output; rvalid tells each one whether it is theirs.
    assign p0_rvalid = rd_pend[0];
    assign p1_rvalid = rd_pend[1];
    assign p0_rdata  = sram_rdata;
    assign p1_rdata  = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM stub, behavioural reference model with per-cycle
// compare, directed scenarios with literal expectations, then randomized traffic.
module tb_sram_arbiter;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [31:0]       p0_wdata, p1_wdata;
    logic [3:0]        p0_wmask, p1_wmask;
    logic              p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0]       p0_rdata, p1_rdata;
    logic              sram_cs, sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [3:0]        sram_wmask;
    logic [31:0]       sram_rdata;
    logic [15:0]       conflict_cnt;

    int checks = 0;
    int errors = 0;

    sram_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .p0_req       (p0_req),
        .p0_we        (p0_we),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_wmask     (p0_wmask),
        .p0_gnt       (p0_gnt),
        .p0_rvalid    (p0_rvalid),
        .p0_rdata     (p0_rdata),
        .p1_req       (p1_req),
        .p1_we        (p1_we),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_wmask     (p1_wmask),
        .p1_gnt       (p1_gnt),
        .p1_rvalid    (p1_rvalid),
        .p1_rdata     (p1_rdata),
        .sram_cs      (sram_cs),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_wmask   (sram_wmask),
        .sram_rdata   (sram_rdata),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'(i) * 32'h9E3779B1 ^ 32'h0F1E2D3C;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // SRAM stub: synchronous read, write committed at the grant edge.
    logic [31:0] stub_mem [DEPTH];
    bit          stub_ready;
    always @(posedge clk) begin
        if (!stub_ready) begin
            for (int i = 0; i < DEPTH; i++) stub_mem[i] = init_val(i);
            stub_ready = 1'b1;
        end
        if (sram_cs) begin
            if (sram_we) stub_mem[sram_addr] = merge(stub_mem[sram_addr], sram_wdata, sram_wmask);
            else         sram_rdata <= stub_mem[sram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: p1 has lost `lost` consecutive cycles and is forced through
    // once that reaches MAX_WAIT; reads return the model memory one cycle later.
    logic [31:0] ref_mem [DEPTH];
    int          lost;
    int          conf;
    bit          pend0, pend1;
    logic [31:0] exp_data;
    bit          e_g0, e_g1;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        lost = 0; conf = 0; pend0 = 0; pend1 = 0; exp_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                lost = 0; conf = 0; pend0 = 0; pend1 = 0;
            end
            e_g1 = p1_req && (!p0_req || lost >= MAX_WAIT);
            e_g0 = p0_req && !e_g1;

            check("p0_gnt", 32'(p0_gnt), 32'(e_g0));
            check("p1_gnt", 32'(p1_gnt), 32'(e_g1));
            check("sram_cs", 32'(sram_cs), 32'(e_g0 | e_g1));
            check("sram_we", 32'(sram_we), 32'(e_g0 ? p0_we : (e_g1 ? p1_we : 1'b0)));
            if (e_g0 || e_g1) begin
                check("sram_addr", 32'(sram_addr), 32'(e_g1 ? p1_addr : p0_addr));
                check("sram_wdata", sram_wdata, e_g1 ? p1_wdata : p0_wdata);
                check("sram_wmask", 32'(sram_wmask), 32'(e_g1 ? p1_wmask : p0_wmask));
            end
            check("p0_rvalid", 32'(p0_rvalid), 32'(pend0));
            check("p1_rvalid", 32'(p1_rvalid), 32'(pend1));
            if (pend0) check("p0_rdata", p0_rdata, exp_data);
            if (pend1) check("p1_rdata", p1_rdata, exp_data);
            check("conflict_cnt", 32'(conflict_cnt), 32'(conf));

            if (!rst) begin
                pend0 = e_g0 && !p0_we;
                pend1 = e_g1 && !p1_we;
                if (e_g0) begin
                    if (p0_we) ref_mem[p0_addr] = merge(ref_mem[p0_addr], p0_wdata, p0_wmask);
                    else       exp_data = ref_mem[p0_addr];
                end else if (e_g1) begin
                    if (p1_we) ref_mem[p1_addr] = merge(ref_mem[p1_addr], p1_wdata, p1_wmask);
                    else       exp_data = ref_mem[p1_addr];
                end
                lost = (p1_req && !e_g1) ? lost + 1 : 0;
                if (p0_req && p1_req && conf < 65535) conf++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask);
        p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_wmask = wmask;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask);
        p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_wmask = wmask;
    endtask

    task automatic idle();
        set_p0(1'b0, 1'b0, '0, '0, '0);
        set_p1(1'b0, 1'b0, '0, '0, '0);
    endtask

    logic g0, g1;
    int   p1_gnt_cycles;

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) next_cycle();
        #2;
        check("reset p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("reset p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("reset conflict_cnt", 32'(conflict_cnt), 32'd0);
        check("reset sram_cs", 32'(sram_cs), 32'd0);
        next_cycle();
        rst = 1'b0;

        $display("[TB] port 0 write then read");
        next_cycle();
        set_p0(1'b1, 1'b1, 13'h010, 32'hDEADBEEF, 4'hF);
        #2;
        check("p0 write gnt", 32'(p0_gnt), 32'd1);
        next_cycle();
        set_p0(1'b1, 1'b0, 13'h010, 32'h0, 4'h0);
        #2;
        check("p0 read gnt", 32'(p0_gnt), 32'd1);
        check("p0 read p1_rvalid", 32'(p1_rvalid), 32'd0);
        next_cycle();
        idle();
        #2;
        check("p0 read rvalid", 32'(p0_rvalid), 32'd1);
        check("p0 read rdata", p0_rdata, 32'hDEADBEEF);
        check("p0 read p1_rvalid late", 32'(p1_rvalid), 32'd0);

        $display("[TB] starvation bound");
        next_cycle();
        p1_gnt_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            set_p0(1'b1, 1'b0, 13'h030, 32'h0, 4'h0);
            set_p1(c <= 4, 1'b0, 13'h020, 32'h0, 4'h0);
            #2;
            check($sformatf("starve p1_gnt c%0d", c), 32'(p1_gnt), 32'(c == 4));
            check($sformatf("starve p0_gnt c%0d", c), 32'(p0_gnt), 32'(c != 4));
            check($sformatf("starve p1_rvalid c%0d", c), 32'(p1_rvalid), 32'(c == 5));
            if (p1_gnt) p1_gnt_cycles++;
        end
        check("starve p1 grant count", 32'(p1_gnt_cycles), 32'd1);

        $display("[TB] alternating reads");
        next_cycle();
        idle();
        next_cycle();
        set_p0(1'b1, 1'b0, 13'h001, 32'h0, 4'h0);
        next_cycle();
        idle();
        set_p1(1'b1, 1'b0, 13'h002, 32'h0, 4'h0);
        #2;
        check("alt rvalid0 c1", 32'(p0_rvalid), 32'd1);
        check("alt rdata0 c1", p0_rdata, init_val(1));
        next_cycle();
        idle();
        set_p0(1'b1, 1'b0, 13'h003, 32'h0, 4'h0);
        #2;
        check("alt rvalid1 c2", 32'(p1_rvalid), 32'd1);
        check("alt rdata1 c2", p1_rdata, init_val(2));
        next_cycle();
        idle();
        #2;
        check("alt rvalid0 c3", 32'(p0_rvalid), 32'd1);
        check("alt rdata0 c3", p0_rdata, init_val(3));

        $display("[TB] byte mask");
        next_cycle();
        set_p0(1'b1, 1'b1, 13'h040, 32'h11223344, 4'hF);
        next_cycle();
        idle();
        set_p1(1'b1, 1'b1, 13'h040, 32'hAABBCCDD, 4'b0101);
        next_cycle();
        idle();
        set_p0(1'b1, 1'b0, 13'h040, 32'h0, 4'h0);
        next_cycle();
        idle();
        #2;
        check("mask rdata", p0_rdata, 32'h11BB33DD);

        $display("[TB] conflict saturation");
        next_cycle();
        set_p0(1'b1, 1'b0, 13'h005, 32'h0, 4'h0);
        set_p1(1'b1, 1'b0, 13'h006, 32'h0, 4'h0);
        repeat (65600) next_cycle();
        #2;
        check("saturated conflict_cnt", 32'(conflict_cnt), 32'h0000FFFF);

        $display("[TB] reset mid-read");
        next_cycle();
        idle();
        next_cycle();
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            set_p0(1'b1, 1'b0, 13'h007, 32'h0, 4'h0);
            set_p1(1'b1, 1'b0, 13'h008, 32'h0, 4'h0);
        end
        #2;
        check("pre-reset conflict nonzero", 32'(conflict_cnt != 16'd0), 32'd1);
        next_cycle();
        rst = 1'b1;
        idle();
        #2;
        check("reset mid-read p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("reset mid-read conflict_cnt", 32'(conflict_cnt), 32'd0);
        next_cycle();
        rst = 1'b0;
        set_p0(1'b1, 1'b0, 13'h009, 32'h0, 4'h0);
        set_p1(1'b1, 1'b0, 13'h00A, 32'h0, 4'h0);
        #2;
        check("post-reset p0_gnt", 32'(p0_gnt), 32'd1);
        check("post-reset p1_gnt", 32'(p1_gnt), 32'd0);
        check("post-reset p0_rvalid", 32'(p0_rvalid), 32'd0);
        next_cycle();
        idle();

        $display("[TB] randomized traffic");
        g0 = 1'b0;
        g1 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            if (!p0_req || g0 || $urandom_range(15) == 0) begin
                set_p0($urandom_range(3) != 0, 1'($urandom_range(1)),
                       ADDR_W'($urandom_range(15)), $urandom, 4'($urandom_range(15)));
            end
            if (!p1_req || g1 || $urandom_range(15) == 0) begin
                set_p1($urandom_range(2) != 0, 1'($urandom_range(1)),
                       ADDR_W'($urandom_range(15)), $urandom, 4'($urandom_range(15)));
            end
            #2;
            g0 = p0_gnt;
            g1 = p1_gnt;
        end

        next_cycle();
        idle();
        repeat (2) next_cycle();
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
